instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader.sv | 274 +++++++++++++++++++++++++++
 tb/tb_instr_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// instr_loader: UART (8N1) boot loader that writes 32-bit instruction words
// into instruction memory and holds the CPU in reset while a load is running.
// Frame: 0xA5, N (word count), 4*N payload bytes big-endian, optional checksum.
// Optional feature macro: INSTR_LOADER_CHECKSUM_EN (XOR checksum byte after payload).
module instr_loader #(
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned TIMEOUT_BITS = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_rx,
  output logic [ADDR_WIDTH-1:0] imem_waddr,
  output logic [31:0]           imem_wdata,
  output logic                  imem_wren,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_err,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int unsigned DIV    = CLK_HZ / BAUD;
  localparam int unsigned HALF   = DIV / 2;
  localparam int unsigned CNT_W  = $clog2(DIV);
  localparam int unsigned TO_CYC = TIMEOUT_BITS * DIV;
  localparam int unsigned TMR_W  = $clog2(TO_CYC + 1);
  localparam int unsigned WC_W   = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH  = 32'(1) << ADDR_WIDTH;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
`ifdef INSTR_LOADER_CHECKSUM_EN
    S_CSUM  = 3'd3,
`endif
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  // ---------------- receiver ----------------
  logic             r_rx_meta;
  logic             r_rx_sync;
  logic             r_rx_prev;
  rx_state_t        r_rx_st;
  rx_state_t        w_rx_st_nxt;
  logic [CNT_W-1:0] r_baud_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_rx_shift;
  logic             w_baud_end;
  logic             w_half_end;
  logic             w_byte_done;
  logic             w_frame_err;

  // ---------------- loader ----------------
  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [31:0]           r_wdata;
  logic                  r_wren;
  logic [WC_W-1:0]       r_wcount;
  logic [WC_W-1:0]       r_len;
  logic [1:0]            r_byte_idx;
  logic [TMR_W-1:0]      r_timer;
  logic                  r_hold;
  logic                  r_done;
  logic                  r_err;
  logic                  w_active;
  logic                  w_timeout;
  logic                  w_abort;
  logic                  w_len_bad;
  logic                  w_last_word;
  logic                  w_is_sync;
  logic                  w_hold_nxt;
  logic                  w_done_nxt;
  logic                  w_err_nxt;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]            r_csum;
`endif

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_baud_end = (r_baud_cnt == CNT_W'(DIV - 1));
  assign w_half_end = (r_baud_cnt == CNT_W'(HALF - 1));

  // Receiver state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rx_st <= RX_IDLE;
    else      r_rx_st <= w_rx_st_nxt;
  end

  // Receiver next state: mid-start glitch check, 8 data bits, stop bit
  always_comb begin
    w_rx_st_nxt = r_rx_st;
    case (r_rx_st)
      RX_IDLE:  if (r_rx_prev && !r_rx_sync) w_rx_st_nxt = RX_START;
      RX_START: if (w_half_end) w_rx_st_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_baud_end && (r_bit_idx == 3'd7)) w_rx_st_nxt = RX_STOP;
      RX_STOP:  if (w_baud_end) w_rx_st_nxt = RX_IDLE;
      default:  w_rx_st_nxt = RX_IDLE;
    endcase
  end

  // Receiver outputs: byte complete or framing error at the stop-bit sample
  always_comb begin
    w_byte_done = 1'b0;
    w_frame_err = 1'b0;
    if ((r_rx_st == RX_STOP) && w_baud_end) begin
      w_byte_done = r_rx_sync;
      w_frame_err = !r_rx_sync;
    end
  end

  // Receiver bit timing counter and LSB-first shift register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_rx_shift <= '0;
    end else begin
      if ((r_rx_st != w_rx_st_nxt) || (r_rx_st == RX_IDLE) || w_baud_end) r_baud_cnt <= '0;
      else                                                              r_baud_cnt <= r_baud_cnt + CNT_W'(1);
      if (r_rx_st == RX_IDLE) begin
        r_bit_idx <= '0;
      end else if ((r_rx_st == RX_DATA) && w_baud_end) begin
        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
        r_bit_idx  <= r_bit_idx + 3'd1;
      end
    end
  end

  // ---------------- loader control ----------------
  assign w_is_sync   = w_byte_done && (r_rx_shift == 8'hA5);
  assign w_len_bad   = (r_rx_shift == 8'h00) || (32'(r_rx_shift) > DEPTH);
  assign w_last_word = (WC_W'(r_wcount + WC_W'(1)) == r_len);
`ifdef INSTR_LOADER_CHECKSUM_EN
  assign w_active    = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CSUM);
`else
  assign w_active    = (r_state == S_LEN) || (r_state == S_DATA);
`endif
  // A byte completing in the expiry cycle wins over the timeout
  assign w_timeout   = w_active && (r_timer == TMR_W'(TO_CYC - 1)) && !w_byte_done;
  assign w_abort     = w_frame_err || w_timeout;

  // Loader state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Loader next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: if (w_is_sync) w_state_nxt = S_LEN;
      S_LEN: begin
        if (w_abort)          w_state_nxt = S_ERROR;
        else if (w_byte_done) w_state_nxt = w_len_bad ? S_ERROR : S_DATA;
      end
      S_DATA: begin
        if (w_abort) w_state_nxt = S_ERROR;
`ifdef INSTR_LOADER_CHECKSUM_EN
        else if (r_wren && w_last_word) w_state_nxt = S_CSUM;
`else
        else if (r_wren && w_last_word) w_state_nxt = S_DONE;
`endif
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (w_abort)          w_state_nxt = S_ERROR;
        else if (w_byte_done) w_state_nxt = (r_rx_shift == r_csum) ? S_DONE : S_ERROR;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Status outputs decoded from the upcoming state so they align with it
  always_comb begin
    w_hold_nxt = 1'b1;
    w_done_nxt = 1'b0;
    w_err_nxt  = 1'b0;
    case (w_state_nxt)
      S_IDLE:  w_hold_nxt = 1'b0;
      S_DONE:  begin w_hold_nxt = 1'b0; w_done_nxt = 1'b1; end
      S_ERROR: w_err_nxt = 1'b1;
      default: w_hold_nxt = 1'b1;
    endcase
  end

  // Status output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_hold <= w_hold_nxt;
      r_done <= w_done_nxt;
      r_err  <= w_err_nxt;
    end
  end

  // Loader datapath: timeout timer, word assembly, write strobe, counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timer    <= '0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_wren     <= 1'b0;
      r_wcount   <= '0;
      r_len      <= '0;
      r_byte_idx <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      r_wren <= 1'b0;
      if (w_byte_done || !w_active) r_timer <= '0;
      else                          r_timer <= r_timer + TMR_W'(1);
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (w_is_sync) begin
            r_waddr    <= '0;
            r_wcount   <= '0;
            r_byte_idx <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            r_csum     <= '0;
`endif
          end
        end
        S_LEN: if (w_byte_done) r_len <= WC_W'(r_rx_shift);
        S_DATA: begin
          if (w_byte_done) begin
            r_wdata    <= {r_wdata[23:0], r_rx_shift};
            r_byte_idx <= r_byte_idx + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
            r_csum     <= r_csum ^ r_rx_shift;
`endif
            if (r_byte_idx == 2'd3) r_wren <= 1'b1;
          end
          if (r_wren) begin
            r_waddr  <= r_waddr + ADDR_WIDTH'(1);
            r_wcount <= r_wcount + WC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_waddr = r_waddr;
  assign imem_wdata = r_wdata;
  assign imem_wren  = r_wren;
  assign cpu_hold   = r_hold;
  assign load_done  = r_done;
  assign load_err   = r_err;
  assign word_count = r_wcount;

endmodule

// File: tb/tb_instr_loader.sv
// Testbench for instr_loader: table of UART load frames with expected final
// status, a write scoreboard fed by a small frame model, and hand-written
// sequences for timeout, glitch, framing error and mid-load reset.
module tb_instr_loader;

  localparam int unsigned DIV    = 10;
  localparam int unsigned AW     = 8;
  localparam int unsigned TO_CYC = 1024 * DIV;
`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          uart_rx;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          imem_wren;
  logic          cpu_hold;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   word_count;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t sb[$];
  wr_t m_exp;

  typedef struct packed {
    logic [3:0]  nb;
    logic [95:0] bytes;
    logic        add_csum;
    logic        done;
    logic        err;
    logic        hold;
    logic [8:0]  wc;
  } vec_t;
  vec_t vt[5];

  // frame model state
  int          m_st = 0;
  logic [7:0]  m_n = '0;
  logic [7:0]  m_cnt = '0;
  logic [1:0]  m_bidx = '0;
  logic [31:0] m_word = '0;
  logic [7:0]  m_xor = '0;
  logic        prev_wren = 1'b0;

  instr_loader #(
    .CLK_HZ(1000000), .BAUD(100000), .ADDR_WIDTH(AW), .TIMEOUT_BITS(1024)
  ) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .imem_wren(imem_wren),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st   = 0;
    m_bidx = '0;
  endtask

  // Expected writes are pushed as each payload byte is driven
  task automatic model_byte(input logic [7:0] b);
    wr_t w;
    case (m_st)
      0: if (b == 8'hA5) begin m_st = 1; m_cnt = '0; m_xor = '0; end
      1: begin m_n = b; m_bidx = '0; m_st = (b == 8'h00) ? 0 : 2; end
      2: begin
        m_word = {m_word[23:0], b};
        m_xor  = m_xor ^ b;
        m_bidx = m_bidx + 2'd1;
        if (m_bidx == 2'd0) begin
          w.addr = m_cnt;
          w.data = m_word;
          sb.push_back(w);
          m_cnt = m_cnt + 8'd1;
          if (m_cnt == m_n) m_st = CSUM_EN ? 3 : 0;
        end
      end
      default: m_st = 0;
    endcase
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    if (stop) model_byte(b);
    @(negedge clk) uart_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rx = stop;
    repeat (DIV) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * DIV) @(negedge clk);
  endtask

  task automatic send_csum();
    if (CSUM_EN) send_byte(m_xor, 1'b1);
  endtask

  task automatic send_word_frame(input logic [31:0] w);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1);
    send_csum();
  endtask

  task automatic chk_status(input string tag, input logic done, input logic err,
                            input logic hold, input logic [8:0] wc);
    chk({tag, ".load_done"}, 32'(load_done), 32'(done));
    chk({tag, ".load_err"}, 32'(load_err), 32'(err));
    chk({tag, ".cpu_hold"}, 32'(cpu_hold), 32'(hold));
    chk({tag, ".word_count"}, 32'(word_count), 32'(wc));
    chk({tag, ".pending_writes"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".imem_waddr"}, 32'(imem_waddr), 32'd0);
    chk({tag, ".imem_wdata"}, imem_wdata, 32'd0);
    chk({tag, ".imem_wren"}, 32'(imem_wren), 32'd0);
    chk({tag, ".cpu_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, ".load_done"}, 32'(load_done), 32'd0);
    chk({tag, ".load_err"}, 32'(load_err), 32'd0);
    chk({tag, ".word_count"}, 32'(word_count), 32'd0);
  endtask

  // Scoreboard: every write strobe must match the next expected write, one cycle wide
  always @(negedge clk) begin
    if (imem_wren) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected",
                 imem_waddr, imem_wdata);
      end else begin
        m_exp = sb.pop_front();
        chk("write.addr", 32'(imem_waddr), 32'(m_exp.addr));
        chk("write.data", imem_wdata, m_exp.data);
      end
      chk("write.one_cycle", 32'(prev_wren), 32'd0);
    end
    prev_wren <= imem_wren;
  end

  initial begin
    vec_t v;
    vt[0] = '{nb: 4'd10, bytes: {80'hA5_02_20_08_00_05_AC_28_00_00, 16'h0},
              add_csum: 1'b1, done: 1'b1, err: 1'b0, hold: 1'b0, wc: 9'd2};
    vt[1] = '{nb: 4'd3, bytes: {24'h00_FF_13, 72'h0},
              add_csum: 1'b0, done: 1'b1, err: 1'b0, hold: 1'b0, wc: 9'd2};
    vt[2] = '{nb: 4'd6, bytes: {48'hA5_01_DE_AD_BE_EF, 48'h0},
              add_csum: 1'b1, done: 1'b1, err: 1'b0, hold: 1'b0, wc: 9'd1};
    vt[3] = '{nb: 4'd2, bytes: {16'hA5_00, 80'h0},
              add_csum: 1'b0, done: 1'b0, err: 1'b1, hold: 1'b1, wc: 9'd0};
    vt[4] = '{nb: 4'd6, bytes: {48'hA5_01_11_22_33_44, 48'h0},
              add_csum: 1'b1, done: 1'b1, err: 1'b0, hold: 1'b0, wc: 9'd1};

    rst     = 1'b0;
    uart_rx = 1'b1;
    repeat (5) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // table-driven frames
    for (int k = 0; k < 5; k++) begin
      v = vt[k];
      for (int i = 0; i < int'(v.nb); i++) send_byte(v.bytes[95 - 8*i -: 8], 1'b1);
      if (v.add_csum) send_csum();
      repeat (2 * DIV) @(negedge clk);
      chk_status($sformatf("vec%0d", k), v.done, v.err, v.hold, v.wc);
    end

    // inter-byte timeout after a partial word, then recovery
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    repeat (TO_CYC - 100) @(negedge clk);
    chk("timeout.before.load_err", 32'(load_err), 32'd0);
    chk("timeout.before.cpu_hold", 32'(cpu_hold), 32'd1);
    repeat (200) @(negedge clk);
    model_reset();
    chk_status("timeout", 1'b0, 1'b1, 1'b1, 9'd0);
    send_word_frame(32'hCAFEBABE);
    repeat (2 * DIV) @(negedge clk);
    chk_status("after_timeout", 1'b1, 1'b0, 1'b0, 9'd1);

    // short low glitch must not start a byte; an immediate frame still loads
    @(negedge clk) uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (8) @(negedge clk);
    send_word_frame(32'h01020304);
    repeat (2 * DIV) @(negedge clk);
    chk_status("glitch", 1'b1, 1'b0, 1'b0, 9'd1);

    // stop bit forced low during payload
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b0);
    repeat (2 * DIV) @(negedge clk);
    model_reset();
    chk_status("frame_err", 1'b0, 1'b1, 1'b1, 9'd0);

    // reset in the middle of word 0
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    chk_reset_outputs("mid_reset");
    rst = 1'b1;
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    repeat (2 * DIV) @(negedge clk);
    chk_status("post_reset", 1'b0, 1'b0, 1'b0, 9'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
